// File: rtl/and_reduce_pkg.sv
// Shared helpers for the AND-reduction tree: level count, latency, per-level widths
// and the node type used by the optional first-zero locator.
package and_reduce_pkg;

  localparam int IDX_W = 8;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } zero_node_t;

  function automatic int levels_f(input int width);
    int l;
    l = 0;
    while ((1 << l) < width) l++;
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int lat_f(input int width, input int pipe_all);
    return (pipe_all != 0) ? levels_f(width) : 1;
  endfunction

  // Number of nodes present at the input of tree level lvl.
  function automatic int lvl_width_f(input int width, input int lvl);
    return (width + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/and_reduce_stage.sv
// One level of the AND tree: pairs adjacent bits, passes an odd leftover through,
// optionally registers data and valid. Carries first-zero nodes when AND_REDUCE_FIRST_ZERO_EN is set.
module and_reduce_stage
  import and_reduce_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter bit REG   = 1'b1,
  parameter bit HOLD  = 1'b0,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [N_IN-1:0]  i_data,
`ifdef AND_REDUCE_FIRST_ZERO_EN
  input  zero_node_t [N_IN-1:0]  i_zn,
  output zero_node_t [N_OUT-1:0] o_zn,
`endif
  output logic             o_vld,
  output logic [N_OUT-1:0] o_data
);

  logic [N_OUT-1:0] w_red;
`ifdef AND_REDUCE_FIRST_ZERO_EN
  zero_node_t [N_OUT-1:0] w_zn;
`endif

  for (genvar j = 0; j < N_OUT; j++) begin : g_node
    if (2 * j + 1 < N_IN) begin : g_pair
      assign w_red[j] = i_data[2*j] & i_data[2*j+1];
`ifdef AND_REDUCE_FIRST_ZERO_EN
      // Lower index wins: take the left child whenever it already holds a zero.
      assign w_zn[j] = i_zn[2*j].found ? i_zn[2*j] : i_zn[2*j+1];
`endif
    end else begin : g_pass
      assign w_red[j] = i_data[2*j];
`ifdef AND_REDUCE_FIRST_ZERO_EN
      assign w_zn[j] = i_zn[2*j];
`endif
    end
  end

  // Stage boundary: optional register; HOLD freezes data while valid is low.
  if (REG) begin : g_reg
    logic             r_vld;
    logic [N_OUT-1:0] r_data;
`ifdef AND_REDUCE_FIRST_ZERO_EN
    zero_node_t [N_OUT-1:0] r_zn;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_data <= '0;
`ifdef AND_REDUCE_FIRST_ZERO_EN
        r_zn   <= '0;
`endif
      end else begin
        r_vld <= i_vld;
        if (i_vld || !HOLD) begin
          r_data <= w_red;
`ifdef AND_REDUCE_FIRST_ZERO_EN
          r_zn   <= w_zn;
`endif
        end
      end
    end
    assign o_vld  = r_vld;
    assign o_data = r_data;
`ifdef AND_REDUCE_FIRST_ZERO_EN
    assign o_zn   = r_zn;
`endif
  end else begin : g_comb
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_vld    = i_vld;
    assign o_data   = w_red;
`ifdef AND_REDUCE_FIRST_ZERO_EN
    assign o_zn     = w_zn;
`endif
  end

endmodule

// File: rtl/and_reduce_param.sv
// Pipelined AND-reduction of WIDTH_I bits to one bit with a travelling valid strobe.
// Optional feature macro AND_REDUCE_FIRST_ZERO_EN adds zero_idx (lowest index of a 0 bit).
module and_reduce_param
  import and_reduce_pkg::*;
#(
  parameter int WIDTH_I  = 3,
  parameter int PIPE_ALL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH_I-1:0] in,
`ifdef AND_REDUCE_FIRST_ZERO_EN
  output logic [levels_f(WIDTH_I)-1:0] zero_idx,
`endif
  output logic               out_valid,
  output logic               out
);

  localparam int LEVELS = levels_f(WIDTH_I);
  localparam int ZW     = LEVELS;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI = lvl_width_f(WIDTH_I, k);
    localparam int NO = lvl_width_f(WIDTH_I, k + 1);

    logic          w_vin;
    logic [NI-1:0] w_din;
    logic          w_vout;
    logic [NO-1:0] w_dout;
`ifdef AND_REDUCE_FIRST_ZERO_EN
    zero_node_t [NI-1:0] w_zin;
    zero_node_t [NO-1:0] w_zout;
`endif

    if (k == 0) begin : g_src
      assign w_vin = in_valid;
      assign w_din = in;
`ifdef AND_REDUCE_FIRST_ZERO_EN
      for (genvar i = 0; i < NI; i++) begin : g_leaf
        assign w_zin[i] = '{found: ~in[i], idx: IDX_W'(i)};
      end
`endif
    end else begin : g_src
      assign w_vin = g_lvl[k-1].w_vout;
      assign w_din = g_lvl[k-1].w_dout;
`ifdef AND_REDUCE_FIRST_ZERO_EN
      assign w_zin = g_lvl[k-1].w_zout;
`endif
    end

    and_reduce_stage #(
      .N_IN (NI),
      .REG  ((PIPE_ALL != 0) || (k == LEVELS - 1)),
      .HOLD (k == LEVELS - 1)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (w_vin),
      .i_data (w_din),
`ifdef AND_REDUCE_FIRST_ZERO_EN
      .i_zn   (w_zin),
      .o_zn   (w_zout),
`endif
      .o_vld  (w_vout),
      .o_data (w_dout)
    );
  end

  assign out_valid = g_lvl[LEVELS-1].w_vout;
  assign out       = g_lvl[LEVELS-1].w_dout[0];

`ifdef AND_REDUCE_FIRST_ZERO_EN
  zero_node_t w_zroot;
  assign w_zroot  = g_lvl[LEVELS-1].w_zout[0];
  assign zero_idx = w_zroot.found ? w_zroot.idx[ZW-1:0] : '0;
  if (ZW < IDX_W) begin : g_idx_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_zroot.idx[IDX_W-1:ZW];
  end
`endif

endmodule

// File: tb/tb_and_reduce_param.sv
// Directed self-checking bench for and_reduce_param across several width/pipeline configurations.
module tb_and_reduce_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v3c = 1'b0, v3p = 1'b0, v8 = 1'b0, v1 = 1'b0;
  logic [2:0] d3c = '0, d3p = '0;
  logic [7:0] d8  = '0;
  logic [0:0] d1  = '0;
  logic       ov3c, ov3p, ov8, ov1;
  logic       o3c, o3p, o8, o1;
`ifdef AND_REDUCE_FIRST_ZERO_EN
  logic [1:0] z3c, z3p;
  logic [2:0] z8;
  logic [0:0] z1;
`endif

  int nchk = 0;
  int nerr = 0;

  and_reduce_param #(.WIDTH_I(3), .PIPE_ALL(0)) u_3c (
    .clk(clk), .rst(rst), .in_valid(v3c), .in(d3c),
`ifdef AND_REDUCE_FIRST_ZERO_EN
    .zero_idx(z3c),
`endif
    .out_valid(ov3c), .out(o3c));

  and_reduce_param #(.WIDTH_I(3), .PIPE_ALL(1)) u_3p (
    .clk(clk), .rst(rst), .in_valid(v3p), .in(d3p),
`ifdef AND_REDUCE_FIRST_ZERO_EN
    .zero_idx(z3p),
`endif
    .out_valid(ov3p), .out(o3p));

  and_reduce_param #(.WIDTH_I(8), .PIPE_ALL(1)) u_8p (
    .clk(clk), .rst(rst), .in_valid(v8), .in(d8),
`ifdef AND_REDUCE_FIRST_ZERO_EN
    .zero_idx(z8),
`endif
    .out_valid(ov8), .out(o8));

  and_reduce_param #(.WIDTH_I(1), .PIPE_ALL(0)) u_1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in(d1),
`ifdef AND_REDUCE_FIRST_ZERO_EN
    .zero_idx(z1),
`endif
    .out_valid(ov1), .out(o1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ov3c", 32'(ov3c), 0); check("rst_o3c", 32'(o3c), 0);
    check("rst_ov3p", 32'(ov3p), 0); check("rst_o3p", 32'(o3p), 0);
    check("rst_ov8",  32'(ov8),  0); check("rst_o8",  32'(o8),  0);
    check("rst_ov1",  32'(ov1),  0); check("rst_o1",  32'(o1),  0);
`ifdef AND_REDUCE_FIRST_ZERO_EN
    check("rst_z8", 32'(z8), 0);
`endif
    rst = 1'b0;

    // WIDTH 3 combinational tree: every code 000..111
    for (int i = 0; i < 8; i++) begin
      d3c = 3'(i); v3c = 1'b1;
      tick();
      check($sformatf("w3c_ov_%0d", i), 32'(ov3c), 1);
      check($sformatf("w3c_o_%0d", i), 32'(o3c), (i == 7) ? 1 : 0);
    end
    v3c = 1'b0; d3c = 3'b000;
    tick();
    check("w3c_idle_ov", 32'(ov3c), 0);
    check("w3c_hold_o", 32'(o3c), 1);

    // Invalid X input must not disturb valid or the held output
    d3c = 3'bxxx;
    tick();
    check("w3c_x_ov", 32'(ov3c), 0);
    check("w3c_x_hold", 32'(o3c), 1);
    d3c = 3'b000;

    // WIDTH 3 fully pipelined (latency 2)
    d3p = 3'b111; v3p = 1'b1;
    tick();
    check("w3p_e1_ov", 32'(ov3p), 0);
    d3p = 3'b110;
    tick();
    check("w3p_e2_ov", 32'(ov3p), 1); check("w3p_e2_o", 32'(o3p), 1);
    v3p = 1'b0; d3p = 3'b000;
    tick();
    check("w3p_e3_ov", 32'(ov3p), 1); check("w3p_e3_o", 32'(o3p), 0);
    tick();
    check("w3p_e4_ov", 32'(ov3p), 0); check("w3p_e4_o", 32'(o3p), 0);

    // WIDTH 8 fully pipelined: single pulse, latency 3, then hold
    d8 = 8'hFF; v8 = 1'b1;
    tick();
    check("w8_e1_ov", 32'(ov8), 0);
    v8 = 1'b0; d8 = 8'h00;
    tick();
    check("w8_e2_ov", 32'(ov8), 0);
    tick();
    check("w8_e3_ov", 32'(ov8), 1); check("w8_e3_o", 32'(o8), 1);
    tick();
    check("w8_e4_ov", 32'(ov8), 0); check("w8_e4_hold", 32'(o8), 1);

`ifdef AND_REDUCE_FIRST_ZERO_EN
    // First-zero locator, back-to-back samples
    d8 = 8'b1110_1011; v8 = 1'b1;
    tick();
    d8 = 8'hFF;
    tick();
    d8 = 8'h7F;
    tick();
    check("fz_eb_ov", 32'(ov8), 1); check("fz_eb_o", 32'(o8), 0); check("fz_eb_idx", 32'(z8), 2);
    v8 = 1'b0; d8 = 8'h00;
    tick();
    check("fz_ff_o", 32'(o8), 1); check("fz_ff_idx", 32'(z8), 0);
    tick();
    check("fz_7f_o", 32'(o8), 0); check("fz_7f_idx", 32'(z8), 7);
    tick();
    check("fz_idle_ov", 32'(ov8), 0); check("fz_hold_idx", 32'(z8), 7);
`endif

    // Reset mid-flight discards the sample and clears the held output
    d8 = 8'hFF; v8 = 1'b1;
    tick();
    v8 = 1'b0; d8 = 8'h00; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w8_rst_ov_%0d", i), 32'(ov8), 0);
      check($sformatf("w8_rst_o_%0d", i), 32'(o8), 0);
      tick();
    end

    // Reset together with a valid sample: reset wins
    d3c = 3'b111; v3c = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; v3c = 1'b0; d3c = 3'b000;
    tick();
    check("w3c_rstv_ov", 32'(ov3c), 0); check("w3c_rstv_o", 32'(o3c), 0);

    // WIDTH 1: one-cycle pass-through
    d1 = 1'b1; v1 = 1'b1;
    tick();
    check("w1_a_ov", 32'(ov1), 1); check("w1_a_o", 32'(o1), 1);
    d1 = 1'b0;
    tick();
    check("w1_b_ov", 32'(ov1), 1); check("w1_b_o", 32'(o1), 0);
    v1 = 1'b0;
    tick();
    check("w1_idle_ov", 32'(ov1), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/and_reduce_param.md
Name: and_reduce_param

Overview:
- Parameterised, pipelined AND-reduction of a WIDTH_I-bit input vector to one bit. Output is 1 only when every input bit is 1.
- Used as the logic-gate leaf of the mux-on-logic datapath, beside the OR/NOT primitives.
- Built as a balanced binary AND tree with optional per-level registers and a valid strobe travelling alongside the data.

Parameters:
- WIDTH_I, 3, number of input bits; legal range 1..256.
- PIPE_ALL, 0, 0 = combinational tree plus one output register; 1 = register after every tree level.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset (sampled on rising clk).
- in_valid  input  1  qualifies in for this cycle.
- in  input  WIDTH_I  operand vector.
- out_valid  output  1  qualifies out.
- out  output  1  registered AND of all bits of the in sample that entered LAT cycles earlier.

Behaviour:
- LEVELS = max(1, ceil(log2(WIDTH_I))); LAT = PIPE_ALL ? LEVELS : 1.
- Tree construction:
  - Level k pairs adjacent bits of level k-1: bit 2j AND bit 2j+1.
  - An odd leftover bit is ANDed with constant 1, i.e. passed through.
  - WIDTH_I=1: out = in[0], delayed by one register.
- Pipeline:
  - Sample taken when in_valid=1.
  - out_valid asserts exactly LAT cycles later with out = &in of that sample.
  - No backpressure; one new sample per cycle, full throughput.
- in_valid=0: the valid bit shifts through as 0, and data registers still load, so their contents are don't-care.
  - out holds its last valid value whenever out_valid=0, so that stage's data register loads only when its valid input is 1.
- Reset: out=0, out_valid=0, all internal valid bits 0, tree registers 0.
  - Reset during operation discards all in-flight samples; out_valid stays 0 for LAT cycles after rst deasserts, until new samples arrive.
- rst and in_valid high together: reset wins and the sample is dropped.
- X on in with in_valid=0 must not propagate to out_valid.

Optional Feature:
- Macro: AND_REDUCE_FIRST_ZERO_EN.
- Defined:
  - Adds output port zero_idx, width max(1, ceil(log2(WIDTH_I))).
  - Gives the lowest index i with in[i]=0, pipeline-aligned with out.
  - Value is 0 when out=1; reset value 0.
  - The tree carries a (zero_found, idx) pair per node; the lower index wins.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package and_reduce_pkg holds:
  - function levels_f(width) returning LEVELS;
  - function lat_f(width, pipe_all);
  - typedef zero_node_t (found bit + index) for the optional feature.
- Sub-module and_reduce_stage: one tree level.
  - Parameterised input width and REG (0/1).
  - Reduces N bits to ceil(N/2) and optionally registers data plus valid.
  - The top level generates LEVELS instances.

Test Plan:
- WIDTH_I=3, PIPE_ALL=0: drive in 000,001,...,111 on consecutive cycles, in_valid=1 → out_valid=1 from cycle 1; out=0 for the first seven, out=1 only for 111 (cycle 8).
- WIDTH_I=3, PIPE_ALL=1 (LAT=2): in=111 then 110 → out=1 at cycle 2, out=0 at cycle 3, out_valid high both cycles.
- WIDTH_I=8, PIPE_ALL=1: in=8'hFF, in_valid single-cycle pulse → out_valid pulses once, exactly 3 cycles later, with out=1; out holds 1 afterwards with out_valid=0.
- Reset mid-flight (WIDTH_I=8, PIPE_ALL=1): in=8'hFF at cycle 0, rst=1 at cycle 1 → out_valid never asserts for that sample; out=0.
- WIDTH_I=1: in=1 then 0 → out=1 then 0, one-cycle latency.
- AND_REDUCE_FIRST_ZERO_EN, WIDTH_I=8: in=8'b1110_1011 → out=0, zero_idx=2; in=8'hFF → out=1, zero_idx=0.
